uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter among NUM_REQ byte producers, sitting between the
//  producers and the transmitter's start/busy/done interface. Round-robin grant,
//  optional per-requester lock for multi-byte packets, and a start watchdog that
//  flags a transmitter which never goes busy.
// PARAMETERS
//  NUM_REQ   4    number of requesters (>=2)
//  DATA_W    8    byte width passed to the transmitter
//  START_TO  64   clk cycles allowed from tx_start to tx_busy before error
// PORTS
//  clk        in   1                system clock
//  rst        in   1                asynchronous reset, active-high
//  req_valid  in   NUM_REQ          requester i has a byte; held until req_ready[i]
//  req_lock   in   NUM_REQ          keep grant after this byte (packet in progress)
//  req_data   in   NUM_REQ*DATA_W   byte of requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          1-cycle accept pulse, one-hot or zero
//  tx_start   out  1                1-cycle pulse: transmitter loads tx_data
//  tx_data    out  DATA_W           byte for transmitter, stable from tx_start to done
//  tx_busy    in   1                transmitter framing a byte
//  tx_done    in   1                1-cycle pulse: stop bit finished
//  grant_id   out  $clog2(NUM_REQ)  current/last granted requester
//  active     out  1                1 while any state other than IDLE
//  err_start  out  1                1-cycle pulse on start watchdog expiry
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0,
//   err_start=0; rr pointer set so requester 0 has highest priority first.
//  FSM (registered, single always_ff on clk/posedge rst):
//   IDLE: if |req_valid -> grant_id <= rr pick, go LOAD; else stay.
//   LOAD: tx_data <= req_data[grant_id]; req_ready[grant_id]=1; tx_start=1
//    (both exactly this one cycle); wdog <= 0; -> WAIT_BUSY.
//   WAIT_BUSY: tx_busy=1 -> WAIT_DONE; tx_done=1 (same or without busy) ->
//    treated as completion, apply DONE rule; wdog==START_TO-1 -> err_start
//    pulse, -> IDLE, rr pointer advances past grant_id.
//   WAIT_DONE: on tx_done apply DONE rule; tx_busy ignored here.
//   DONE rule: if lock_q & req_valid[grant_id] -> LOAD, same grant_id;
//    else rr pointer <= grant_id+1 (mod NUM_REQ), -> IDLE.
//  lock_q = req_lock[grant_id] sampled in LOAD cycle with the byte.
//  Latency: valid seen in IDLE cycle N -> tx_start/req_ready in N+1. Locked
//   back-to-back byte: tx_start one cycle after tx_done.
//  RR pick: first set req_valid at or after pointer, wrapping NUM_REQ-1 -> 0.
//  Requester withdrawing valid before ready: allowed, no byte taken. Data
//   changes after ready: ignored (tx_data latched).
//  wdog: $clog2(START_TO+1) bits, saturating, counts only in WAIT_BUSY.
//  Reset mid-operation: immediate return to reset values; no partial pulse.
//  Never two tx_start without an intervening tx_done or err_start.
// STRUCTURE
//  Shared package uart_pkg: arb_state_t enum {IDLE, LOAD, WAIT_BUSY,
//   WAIT_DONE}; ARB_START_TO_DEF constant.
//  Sub-module rr_arbiter (NUM_REQ): comb picker, inputs req, ptr; outputs
//   gnt_id, gnt_valid. Pointer register stays in uart_tx_arbiter.
//  Integrate with the existing transmitter: its start/busy/done interface is
//   driven by this block.
// TESTING
//  1 Reset, req_valid=4'b0001 data0=8'hA5 -> tx_start/req_ready[0] next cycle,
//    tx_data=8'hA5, grant_id=0.
//  2 All four valid continuously, no lock -> grants 0,1,2,3,0 in order, one
//    tx_start per tx_done.
//  3 Req1 lock=1 for 3 bytes (11,22,33), req2 valid -> 11,22,33 on req1 then
//    req2; each locked start exactly 1 cycle after tx_done.
//  4 tx_busy held low after start, START_TO=8 -> err_start on 8th cycle,
//    active=0 next cycle, next grant goes to following requester.
//  5 rst asserted in WAIT_DONE -> all outputs 0 asynchronously; after release,
//    requester 0 wins over 2 when both valid.
//  6 tx_done same cycle as first tx_busy -> completion taken, no hang.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART transmit-side blocks.
//   Contents:
//     arb_state_t       arbiter FSM states
//     ARB_START_TO_DEF  default start watchdog limit in clk cycles
//     rrNext            round-robin successor of a requester index
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam int ARB_START_TO_DEF = 64;

  // The pointer moves one past the requester just served and wraps at n, so
  // non-power-of-two requester counts also rotate correctly.
  function automatic int rrNext(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. It picks the first asserted request at
//   or after the pointer and wraps from NUM_REQ-1 to 0. It holds no state; the
//   pointer register belongs to the instantiating block.
//   Ports:
//     req        in   NUM_REQ  request vector
//     ptr        in   IDW      index that has highest priority this cycle
//     gnt_id     out  IDW      chosen index (0 when nothing is requested)
//     gnt_valid  out  1        some request is asserted
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid
);

  int idx;

  // Scan from the farthest offset back to the pointer itself. The last hit
  // wins, so the request nearest the pointer gets the grant.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        gnt_id    = IDW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Lets NUM_REQ byte producers share one UART transmitter. Grants rotate
//   round-robin. A requester can hold its grant across a multi-byte packet
//   with req_lock. A watchdog flags a transmitter that never reports busy
//   after it was started.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     req_valid    per-requester byte available, held until req_ready
//     req_lock     per-requester keep-grant request, sampled with the byte
//     req_data     packed bytes, requester i at [i*DATA_W +: DATA_W]
//     req_ready    one-cycle accept pulse, one-hot or zero
//     tx_start     one-cycle pulse telling the transmitter to load tx_data
//     tx_data      byte for the transmitter, stable until completion
//     tx_busy      transmitter is framing a byte
//     tx_done      one-cycle pulse when the stop bit has finished
//     grant_id     current or most recently granted requester
//     active       high in every state other than IDLE
//     err_start    one-cycle pulse when the start watchdog expires
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 8,
  parameter  int START_TO = ARB_START_TO_DEF,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int WDW      = $clog2(START_TO + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDW-1:0]            grant_id,
  output logic                      active,
  output logic                      err_start
);

  arb_state_t          state_q;
  logic [IDW-1:0]      rrPtr_q;
  logic [IDW-1:0]      grantId_q;
  logic                lock_q;
  logic [WDW-1:0]      wdog_q;
  logic [NUM_REQ-1:0]  reqReady_q;
  logic                txStart_q;
  logic [DATA_W-1:0]   txData_q;

  logic [IDW-1:0]      pickId;
  logic                pickValid;
  logic [IDW-1:0]      loadId;
  logic [DATA_W-1:0]   loadData;
  logic                loadLock;
  logic [NUM_REQ-1:0]  loadOneHot;
  logic [IDW-1:0]      nextPtr;
  logic                doneSeen;
  logic                relock;
  logic                wdogExpired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) uPicker (
    .req       (req_valid),
    .ptr       (rrPtr_q),
    .gnt_id    (pickId),
    .gnt_valid (pickValid)
  );

  // A byte is loaded either from IDLE, for the fresh round-robin pick, or
  // straight out of a completion, for the requester that holds the lock. Both
  // paths latch data, lock and the ready pulse on the same edge. That way
  // tx_data is already valid during the tx_start cycle.
  assign loadId     = (state_q == IDLE) ? pickId : grantId_q;
  assign loadData   = req_data[int'(loadId)*DATA_W +: DATA_W];
  assign loadLock   = req_lock[loadId];
  assign loadOneHot = NUM_REQ'(1) << loadId;
  assign nextPtr    = IDW'(rrNext(int'(grantId_q), NUM_REQ));

  // A done pulse ends the byte whether or not busy was ever seen. This keeps
  // a fast transmitter that asserts busy and done together from hanging us.
  assign doneSeen    = tx_done && (state_q == WAIT_BUSY || state_q == WAIT_DONE);
  assign relock      = lock_q && req_valid[grantId_q];
  assign wdogExpired = (state_q == WAIT_BUSY) && !tx_done && !tx_busy &&
                       (wdog_q == WDW'(START_TO - 1));

  // Main FSM. The pulse outputs default low every cycle and are raised only
  // on the edge that enters LOAD, so each pulse lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      grantId_q  <= '0;
      lock_q     <= 1'b0;
      wdog_q     <= '0;
      reqReady_q <= '0;
      txStart_q  <= 1'b0;
      txData_q   <= '0;
    end else begin
      reqReady_q <= '0;
      txStart_q  <= 1'b0;
      if (doneSeen) begin
        if (relock) begin
          txData_q   <= loadData;
          lock_q     <= loadLock;
          reqReady_q <= loadOneHot;
          txStart_q  <= 1'b1;
          state_q    <= LOAD;
        end else begin
          rrPtr_q <= nextPtr;
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (pickValid) begin
              grantId_q  <= pickId;
              txData_q   <= loadData;
              lock_q     <= loadLock;
              reqReady_q <= loadOneHot;
              txStart_q  <= 1'b1;
              state_q    <= LOAD;
            end
          end
          LOAD: begin
            wdog_q  <= '0;
            state_q <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (tx_busy) begin
              state_q <= WAIT_DONE;
            end else if (wdogExpired) begin
              rrPtr_q <= nextPtr;
              state_q <= IDLE;
            end else if (wdog_q != '1) begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
          WAIT_DONE: begin
            state_q <= WAIT_DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign req_ready = reqReady_q;
  assign tx_start  = txStart_q;
  assign tx_data   = txData_q;
  assign grant_id  = grantId_q;
  assign active    = (state_q != IDLE);
  // The error pulse shows in the last WAIT_BUSY cycle. active drops on the
  // cycle after it, when the FSM is back in IDLE.
  assign err_start = wdogExpired;

endmodule
